fir_seq_ctrl: RTL

Controller that sequences the audio FIR bank (band filters such as the B2 band) once per incoming stereo sample frame. It receives a frame-ready strobe from the sample circular queue and generates the shared `sequencing` strobe that every band filter consumes. It also drives the queue read address so samples stay aligned with each filter's coefficient ROM, and it flags when filter outputs are valid. Frames that arrive while a convolution is running are buffered one deep; any further frames are dropped and flagged.

---
 rtl/fir_seq_pkg.sv | 27 ++
 rtl/fir_seq_ctrl_circ_ptr.sv | 31 +++
 rtl/fir_seq_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the FIR bank sequencer: state encoding, default sizes,
// and modular pointer subtraction used to find the oldest sample of a frame.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_TAPS_DFLT = 1021;
    localparam int QDEPTH_DFLT   = 1536;

    // (ptr - n) mod depth; ptr < depth and n < depth, depth added first so nothing goes negative
    function automatic logic [31:0] wrap_sub(input logic [31:0] ptr,
                                             input logic [31:0] n,
                                             input logic [31:0] depth);
        logic [31:0] sum;
        sum = ptr + depth - n;
        if (sum >= depth) begin
            wrap_sub = sum - depth;
        end else begin
            wrap_sub = sum;
        end
    endfunction

endpackage

// File: rtl/fir_seq_ctrl_circ_ptr.sv
// Loadable pointer that increments modulo DEPTH; drives the sample queue read address.
module circ_ptr #(
    parameter int DEPTH = 16,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Load has priority over increment; increment wraps DEPTH-1 back to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= {W{1'b0}};
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            if (ptr == W'(DEPTH - 1)) begin
                ptr <= {W{1'b0}};
            end else begin
                ptr <= ptr + W'(1);
            end
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequences the audio FIR band filters once per stereo frame, with a one-deep frame buffer.
// Optional macro FIR_SEQ_DROP_CNT_EN adds a saturating dropped-frame counter output.
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int NUM_TAPS    = NUM_TAPS_DFLT,
    parameter int QUEUE_DEPTH = QDEPTH_DFLT,
    parameter int PTR_W       = $clog2(QUEUE_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frm_vld,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic             clr_ovfl,
    output logic             sequencing,
    output logic [PTR_W-1:0] rd_addr,
    output logic             fir_vld,
    output logic             busy,
`ifdef FIR_SEQ_DROP_CNT_EN
    output logic [15:0]      drop_cnt,
`endif
    output logic             ovfl
);

    localparam int TAPS_MOD = NUM_TAPS % QUEUE_DEPTH;
    localparam int CNT_W    = $clog2(NUM_TAPS + 1);

    state_e             state_r;
    logic [CNT_W-1:0]   tap_cnt_r;
    logic               pend_vld_r;
    logic [PTR_W-1:0]   pend_ptr_r;

    logic               start_s;
    logic [PTR_W-1:0]   start_ptr_s;
    logic [PTR_W-1:0]   base_s;
    logic               last_tap_s;
    logic               inc_s;
    logic               drop_s;

    // Frame start decision; a pending frame always wins over a fresh strobe
    always_comb begin
        start_s     = 1'b0;
        start_ptr_s = wr_ptr;
        if (state_r == IDLE) begin
            start_s = pend_vld_r | frm_vld;
        end else begin
            start_s = 1'b0;
        end
        if (pend_vld_r) begin
            start_ptr_s = pend_ptr_r;
        end else begin
            start_ptr_s = wr_ptr;
        end
        base_s     = PTR_W'(wrap_sub(32'(start_ptr_s), 32'(TAPS_MOD), 32'(QUEUE_DEPTH)));
        last_tap_s = (tap_cnt_r == CNT_W'(NUM_TAPS));
        inc_s      = (state_r == RUN) && !last_tap_s;
        drop_s     = frm_vld && pend_vld_r && (state_r != IDLE);
    end

    circ_ptr #(
        .DEPTH (QUEUE_DEPTH),
        .W     (PTR_W)
    ) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_s),
        .load_val (base_s),
        .inc      (inc_s),
        .ptr      (rd_addr)
    );

    // Main FSM with registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            tap_cnt_r  <= {CNT_W{1'b0}};
            sequencing <= 1'b0;
            fir_vld    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    fir_vld   <= 1'b0;
                    tap_cnt_r <= {CNT_W{1'b0}};
                    if (start_s) begin
                        state_r    <= RUN;
                        sequencing <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        sequencing <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                RUN: begin
                    // One extra cycle beyond NUM_TAPS primes the synchronous reads
                    if (last_tap_s) begin
                        state_r    <= DONE;
                        sequencing <= 1'b0;
                        fir_vld    <= 1'b1;
                    end else begin
                        state_r   <= RUN;
                        tap_cnt_r <= tap_cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    fir_vld <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    tap_cnt_r  <= {CNT_W{1'b0}};
                    sequencing <= 1'b0;
                    fir_vld    <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // One-deep pending slot; refilled in the same IDLE cycle that drains it
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_r <= 1'b0;
            pend_ptr_r <= {PTR_W{1'b0}};
        end else if (state_r == IDLE) begin
            if (pend_vld_r && frm_vld) begin
                pend_vld_r <= 1'b1;
                pend_ptr_r <= wr_ptr;
            end else begin
                pend_vld_r <= 1'b0;
                pend_ptr_r <= pend_ptr_r;
            end
        end else if (frm_vld && !pend_vld_r) begin
            pend_vld_r <= 1'b1;
            pend_ptr_r <= wr_ptr;
        end else begin
            pend_vld_r <= pend_vld_r;
            pend_ptr_r <= pend_ptr_r;
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set
    always_ff @(posedge clk) begin
        if (rst) begin
            ovfl <= 1'b0;
        end else if (drop_s) begin
            ovfl <= 1'b1;
        end else if (clr_ovfl) begin
            ovfl <= 1'b0;
        end else begin
            ovfl <= ovfl;
        end
    end

`ifdef FIR_SEQ_DROP_CNT_EN
    // Saturating drop counter; clear plus drop in one cycle leaves exactly one
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'd0;
        end else if (drop_s) begin
            if (clr_ovfl) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end else begin
                drop_cnt <= drop_cnt;
            end
        end else if (clr_ovfl) begin
            drop_cnt <= 16'd0;
        end else begin
            drop_cnt <= drop_cnt;
        end
    end
`endif

endmodule
